// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1-to-8 slot collector.
package demux_pkg;

  localparam int N_SLOTS = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/demux1to8_collector_dec3to8.sv
// 3-bit index to 8-bit one-hot write enable, gated by a write strobe.
module dec3to8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  // One-hot decode of the slot index; all zero when no write is happening
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to8_collector.sv
// Steers single-slot writes into an 8-slot frame. Once every slot has been
// written at least once, the frame is held on w until the consumer takes it.
module demux1to8_collector #(
  parameter int DATA_W  = 1,
  parameter int N_SLOTS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [2:0]                s,
  input  logic                      flush,
  output logic [N_SLOTS*DATA_W-1:0] w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_SLOTS-1:0]        filled,
  output logic [2:0]                slot_ptr
);

  import demux_pkg::*;

  state_e                    state_q, state_d;
  logic [N_SLOTS*DATA_W-1:0] w_q;
  logic [N_SLOTS-1:0]        filled_q, filled_d;
  logic [SEL_W-1:0]          slot_ptr_q, slot_ptr_d;

  logic             wr;
  logic             clear;
  logic             complete;
  logic [SEL_W-1:0] idx;
  logic [7:0]       we;

  // A write needs room (COLLECT) and loses to flush
  assign wr    = in_valid && (state_q == COLLECT) && !flush;
  assign idx   = mode ? s : slot_ptr_q;
  // Frame restart: explicit abandon, or the consumer taking a held frame
  assign clear = flush || ((state_q == HOLD) && out_ready);

  dec3to8 u_dec (
    .idx_i    (idx),
    .en_i     (wr),
    .onehot_o (we)
  );

  // Filled bits are OR-ed, so rewriting a slot never double-counts
  assign complete = wr && ((filled_q | we) == '1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over everything in both states
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (!flush && complete) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush || out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Handshake outputs decode from state only, no input-to-output paths
  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == HOLD);
  end

  // Next values of the fill mask and auto pointer
  always_comb begin
    filled_d   = filled_q | we;
    slot_ptr_d = slot_ptr_q;
    if (wr && !mode) begin
      slot_ptr_d = slot_ptr_q + SEL_W'(1);
    end
    if (clear) begin
      filled_d   = '0;
      slot_ptr_d = '0;
    end
  end

  // Fill mask and auto pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q   <= '0;
      slot_ptr_q <= '0;
    end else begin
      filled_q   <= filled_d;
      slot_ptr_q <= slot_ptr_d;
    end
  end

  // Slot data; only reset clears it, stale slots survive flush and handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
    end else begin
      for (int k = 0; k < N_SLOTS; k++) begin
        if (we[k]) begin
          w_q[k*DATA_W +: DATA_W] <= din;
        end
      end
    end
  end

  assign w        = w_q;
  assign filled   = filled_q;
  assign slot_ptr = slot_ptr_q;

endmodule

// File: tb/tb_demux1to8_collector.sv
// Directed bench for demux1to8_collector with DATA_W = 1.
module tb_demux1to8_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] din = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mode = 1'b0;
  logic [2:0] s = '0;
  logic       flush = 1'b0;
  logic [7:0] w;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] filled;
  logic [2:0] slot_ptr;

  int checks = 0;
  int errors = 0;

  demux1to8_collector #(.DATA_W(1), .N_SLOTS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .s         (s),
    .flush     (flush),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .filled    (filled),
    .slot_ptr  (slot_ptr)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (w !== 8'h00) begin errors++; $display("FAIL reset_w got %h exp 00", w); end
    checks++; if (filled !== 8'h00) begin errors++; $display("FAIL reset_filled got %h exp 00", filled); end
    checks++; if (slot_ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", slot_ptr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_auto;
    logic [7:0] dv;
    logic [8:0] ef;
    dv = 8'b0100_1101;  // slot k receives dv[k]: 1,0,1,1,0,0,1,0
    mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      din = dv[k];
      step();
      ef = (9'd1 << (k + 1)) - 9'd1;
      checks++; if (slot_ptr !== 3'((k + 1) % 8)) begin errors++; $display("FAIL auto_ptr[%0d] got %0d exp %0d", k, slot_ptr, (k + 1) % 8); end
      checks++; if (filled !== ef[7:0]) begin errors++; $display("FAIL auto_filled[%0d] got %h exp %h", k, filled, ef[7:0]); end
      checks++; if (out_valid !== (k == 7)) begin errors++; $display("FAIL auto_out_valid[%0d] got %b exp %b", k, out_valid, (k == 7)); end
    end
    in_valid = 1'b0;
    checks++; if (w !== 8'h4D) begin errors++; $display("FAIL auto_w got %h exp 4d", w); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL auto_in_ready got %b exp 0", in_ready); end
  endtask

  task automatic test_hold_backpressure;
    in_valid = 1'b1;
    mode = 1'b0;
    din = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (w !== 8'h4D) begin errors++; $display("FAIL hold_w[%0d] got %h exp 4d", c, w); end
      checks++; if (slot_ptr !== 3'd0) begin errors++; $display("FAIL hold_ptr[%0d] got %0d exp 0", c, slot_ptr); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid[%0d] got %b exp 1", c, out_valid); end
      checks++; if (filled !== 8'hFF) begin errors++; $display("FAIL hold_filled[%0d] got %h exp ff", c, filled); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handoff_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handoff_in_ready got %b exp 1", in_ready); end
    checks++; if (filled !== 8'h00) begin errors++; $display("FAIL handoff_filled got %h exp 00", filled); end
    checks++; if (slot_ptr !== 3'd0) begin errors++; $display("FAIL handoff_ptr got %0d exp 0", slot_ptr); end
    checks++; if (w !== 8'h4D) begin errors++; $display("FAIL handoff_w got %h exp 4d", w); end
  endtask

  task automatic test_addressed;
    logic [2:0] sl [9];
    logic       dl [9];
    logic [7:0] ef;
    sl = '{3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    dl = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ef = 8'h00;
    mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      s = sl[i];
      din = dl[i];
      step();
      ef = ef | (8'h01 << sl[i]);
      checks++; if (filled !== ef) begin errors++; $display("FAIL addr_filled[%0d] got %h exp %h", i, filled, ef); end
      checks++; if (out_valid !== (i == 8)) begin errors++; $display("FAIL addr_out_valid[%0d] got %b exp %b", i, out_valid, (i == 8)); end
      checks++; if (slot_ptr !== 3'd0) begin errors++; $display("FAIL addr_ptr[%0d] got %0d exp 0", i, slot_ptr); end
    end
    in_valid = 1'b0;
    checks++; if (w !== 8'hF7) begin errors++; $display("FAIL addr_w got %h exp f7", w); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addr_release got %b exp 1", in_ready); end
  endtask

  task automatic test_flush;
    mode = 1'b0;
    din = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      step();
    end
    checks++; if (slot_ptr !== 3'd5) begin errors++; $display("FAIL preflush_ptr got %0d exp 5", slot_ptr); end
    checks++; if (filled !== 8'h1F) begin errors++; $display("FAIL preflush_filled got %h exp 1f", filled); end
    flush = 1'b1;
    din = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (filled !== 8'h00) begin errors++; $display("FAIL flush_filled got %h exp 00", filled); end
    checks++; if (slot_ptr !== 3'd0) begin errors++; $display("FAIL flush_ptr got %0d exp 0", slot_ptr); end
    checks++; if (w !== 8'hE0) begin errors++; $display("FAIL flush_w got %h exp e0", w); end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      din = 1'b1;
      step();
      checks++; if (out_valid !== (i == 7)) begin errors++; $display("FAIL refill_out_valid[%0d] got %b exp %b", i, out_valid, (i == 7)); end
    end
    in_valid = 1'b0;
    checks++; if (w !== 8'hFF) begin errors++; $display("FAIL refill_w got %h exp ff", w); end
  endtask

  task automatic test_reset_in_hold;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_hold got %b exp 1", out_valid); end
    rst = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    din = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (w !== 8'h00) begin errors++; $display("FAIL rsthold_w got %h exp 00", w); end
    checks++; if (filled !== 8'h00) begin errors++; $display("FAIL rsthold_filled got %h exp 00", filled); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rsthold_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rsthold_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_wrap;
    logic       ml [10];
    logic [2:0] sl [10];
    logic [2:0] ep [10];
    ml = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sl = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    ep = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      mode = ml[i];
      s = sl[i];
      din = 1'b1;
      step();
      checks++; if (slot_ptr !== ep[i]) begin errors++; $display("FAIL wrap_ptr[%0d] got %0d exp %0d", i, slot_ptr, ep[i]); end
      checks++; if (out_valid !== (i == 9)) begin errors++; $display("FAIL wrap_out_valid[%0d] got %b exp %b", i, out_valid, (i == 9)); end
      if (i == 8) begin
        checks++; if (filled !== 8'h7F) begin errors++; $display("FAIL wrap_filled9 got %h exp 7f", filled); end
      end
    end
    in_valid = 1'b0;
    mode = 1'b0;
    flush = 1'b1;
    out_ready = 1'b0;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL holdflush_out_valid got %b exp 0", out_valid); end
    checks++; if (filled !== 8'h00) begin errors++; $display("FAIL holdflush_filled got %h exp 00", filled); end
    checks++; if (w !== 8'hFF) begin errors++; $display("FAIL holdflush_w got %h exp ff", w); end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_hold_backpressure();
    test_addressed();
    test_flush();
    test_reset_in_hold();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to8_collector.md
DEMUX1TO8_COLLECTOR -- requirements
Module: demux1to8_collector

Interface
REQ-001 Parameter: DATA_W, 1, width of one slot in bits.
REQ-002 Parameter: N_SLOTS, 8, number of output slots; fixed at 8, select width 3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din  input  DATA_W  data to be steered into one slot.
REQ-006 in_valid  input  1  din/s/mode valid this cycle.
REQ-007 in_ready  output  1  block accepts a write this cycle.
REQ-008 mode  input  1  0 = auto-sequential slot pointer, 1 = addressed by s.
REQ-009 s  input  3  slot select in addressed mode; ignored in auto mode.
REQ-010 flush  input  1  abandon the current frame and return to collecting.
REQ-011 w  output  8*DATA_W  collected frame; slot k occupies w[k*DATA_W +: DATA_W].
REQ-012 out_valid  output  1  complete frame held on w.
REQ-013 out_ready  input  1  consumer takes the frame.
REQ-014 filled  output  8  one bit per slot, set once that slot has been written this frame.
REQ-015 slot_ptr  output  3  current auto-mode write pointer.

Function
REQ-016 The block SHALL be a two-state FSM: COLLECT and HOLD.
REQ-017 COLLECT: in_ready = 1 and out_valid = 0; HOLD: in_ready = 0 and out_valid = 1.
REQ-018 A write occurs when in_valid && in_ready && !flush. The target index is s when mode = 1, otherwise slot_ptr.
REQ-019 On a write, w[index] <= din and filled[index] <= 1 at the same clock edge.
REQ-020 In auto mode, slot_ptr SHALL increment modulo 8 on each write (7 wraps to 0). In addressed mode, slot_ptr SHALL hold its value.
REQ-021 A rewrite of an already-filled slot SHALL overwrite its data and SHALL NOT count twice toward completion.
REQ-022 When a write makes filled all ones, the FSM SHALL enter HOLD on that same edge, so out_valid rises one cycle after the 8th distinct write.
REQ-023 In HOLD, w SHALL be stable and in_valid SHALL be ignored (no writes, no pointer movement).
REQ-024 In HOLD with out_ready = 1, the FSM SHALL return to COLLECT at the next edge, with filled <= 0 and slot_ptr <= 0. Writes resume the cycle after.
REQ-025 w SHALL NOT be cleared on handoff or flush; stale slot data remains until overwritten.
REQ-026 flush has priority over in_valid and out_ready in both states: next state COLLECT, filled <= 0, slot_ptr <= 0, no write that cycle.
REQ-027 mode SHALL be allowed to change between any two writes; filled semantics are unaffected.
REQ-028 Combinational input-to-output paths SHALL be limited to none: in_ready and out_valid decode from state only.

Reset
REQ-029 While rst = 1 at a clock edge: state <= COLLECT, w <= 0, filled <= 0, slot_ptr <= 0, out_valid = 0, in_ready = 1 after the edge.
REQ-030 rst SHALL override flush, in_valid and out_ready. Reset mid-frame or in HOLD SHALL discard the frame completely.

Structure
REQ-031 A shared package demux_pkg SHALL hold N_SLOTS, SEL_W = 3, and the state encoding (COLLECT = 1'b0, HOLD = 1'b1).
REQ-032 One sub-module, dec3to8 (3-bit index to 8-bit one-hot write enable, gated by a write strobe), SHALL be instantiated. Everything else is in the top.

Verification
REQ-033 Auto mode, DATA_W = 1: 8 writes of din = 1,0,1,1,0,0,1,0 -> out_valid = 1 on the cycle after the 8th write, w = 8'b0100_1101, in_ready = 0.
REQ-034 Addressed mode: writes to s = 3,3,0,1,2,4,5,6,7, with din = 1 for the first write to s=3 and din = 0 for the second -> completes only after the 9th write, w[3] = 0, filled stays 8'hFF.
REQ-035 HOLD backpressure: hold out_ready = 0 for 5 cycles while in_valid = 1 -> w unchanged, slot_ptr unchanged. Then out_ready = 1 -> next cycle state COLLECT, filled = 0, slot_ptr = 0.
REQ-036 Flush after 5 auto writes -> next cycle filled = 0, slot_ptr = 0, w retains the 5 written slots. Then 8 new writes -> out_valid after the 8th.
REQ-037 Assert rst in HOLD together with out_ready = 1 and flush = 1 -> next cycle w = 0, filled = 0, out_valid = 0, in_ready = 1.
REQ-038 Auto-pointer wrap: switch mode 0 -> 1 -> 0 across 10 writes -> slot_ptr moves only on mode-0 writes and wraps 7 -> 0.
